// File: rtl/ram_dump_tx.sv
// Reads RAM addresses 0..NUM_WORDS-1 in order and sends each byte as an 8N1 UART frame.
// Every output is registered; the comb blocks produce the next values of the registers.
module ram_dump_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 4,
  parameter int NUM_WORDS    = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]     BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, LOAD, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [TW-1:0]     timer, timer_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [7:0]        shreg, shreg_next;
  logic [ADDR_W-1:0] addr_next;
  logic              tx_next, busy_next, done_next;
  logic              bit_end;

  assign bit_end = (timer == BIT_LAST);

  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      mem_addr <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      mem_addr <= addr_next;
      tx       <= tx_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADDR;
      ADDR:    state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (bit_end) state_next = (mem_addr == ADDR_LAST) ? IDLE : ADDR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    timer_next   = '0;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    addr_next    = mem_addr;
    busy_next    = (state_next != IDLE);
    done_next    = (state == STOP) && (state_next == IDLE);

    // Timer restarts on every state entry and at each bit boundary inside DATA.
    if ((state == START || state == DATA || state == STOP) && !bit_end)
      timer_next = timer + 1'b1;

    case (state)
      IDLE:  if (state_next == ADDR) addr_next = '0;
      LOAD:  shreg_next = mem_data;
      START: bit_idx_next = '0;
      DATA: begin
        if (bit_end) begin
          shreg_next   = shreg >> 1;
          bit_idx_next = bit_idx + 3'd1;
        end
      end
      STOP:  if (state_next == ADDR) addr_next = mem_addr + 1'b1;
      default: ;
    endcase

    // tx is registered, so it anticipates the shift that happens on the same edge.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = (state == DATA && bit_end) ? shreg[1] : shreg[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Directed bench for ram_dump_tx: a one-word instance checked cycle by cycle and a
// sixteen-word instance checked through a UART frame decoder.
module tb_ram_dump_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       clear, start1, start16;
  logic [3:0] addr1, addr16;
  logic [7:0] rd1, rd16;
  logic       tx1, busy1, done1, tx16, busy16, done16;
  logic [7:0] mem16 [0:15];
  logic [7:0] frames [0:31];
  logic [7:0] first [0:15];
  int n_checks = 0;
  int n_err = 0;
  int n_frames, done_cyc;

  always #5 clk = ~clk;

  always @(posedge clk) rd16 <= mem16[addr16];
  always @(posedge clk) rd1 <= (addr1 == 4'd0) ? 8'h3C : 8'h00;

  ram_dump_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .NUM_WORDS(1)) dut1 (
    .clock(clk), .clear(clear), .start(start1), .mem_addr(addr1),
    .mem_data(rd1), .tx(tx1), .busy(busy1), .done(done1)
  );

  ram_dump_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .NUM_WORDS(16)) dut16 (
    .clock(clk), .clear(clear), .start(start16), .mem_addr(addr16),
    .mem_data(rd16), .tx(tx16), .busy(busy16), .done(done16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept a start on the next edge (E0) and check the immediate response.
  task automatic start_dump16;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    check("start busy", busy16, 1);
    check("start addr", addr16, 0);
  endtask

  // Runs from E0 until done (or the budget), decoding frames; optional extra start pulse.
  task automatic run_dump(input int max_cyc, input int pulse_at);
    int st;
    int k;
    logic [7:0] sh;
    n_frames = 0;
    done_cyc = -1;
    st = -1;
    sh = '0;
    for (int n = 1; n <= max_cyc; n++) begin
      if (n == pulse_at) start16 = 1'b1;
      else if (n == pulse_at + 1) start16 = 1'b0;
      tick();
      if (done16 === 1'b1) begin
        done_cyc = n;
        break;
      end
      if (st < 0) begin
        if (tx16 === 1'b0) st = n;
      end else begin
        k = n - st;
        if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) sh = {tx16, sh[7:1]};
        if (k == 38) begin
          check("stop bit", tx16, 1);
          if (n_frames < 32) frames[n_frames] = sh;
          n_frames++;
          st = -1;
        end
      end
    end
  endtask

  task automatic check_dump(input string tag);
    check({tag, " frame count"}, n_frames, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s byte %0d", tag, i), frames[i], 32'hF0 + i);
    check({tag, " done cycle"}, done_cyc, 672);
    check({tag, " final addr"}, addr16, 15);
    check({tag, " busy at done"}, busy16, 0);
  endtask

  initial begin
    logic [7:0] b;
    int exp_tx;
    int extra;
    b = 8'h3C;
    for (int i = 0; i < 16; i++) mem16[i] = 8'(8'hF0 + i);

    // Reset held with start high
    clear = 1'b0;
    start1 = 1'b1;
    start16 = 1'b1;
    repeat (3) begin
      tick();
      check("rst tx", tx16, 1);
      check("rst busy", busy16, 0);
      check("rst done", done16, 0);
      check("rst addr", addr16, 0);
      check("rst tx1", tx1, 1);
      check("rst busy1", busy1, 0);
    end
    clear = 1'b1;
    start1 = 1'b0;
    start16 = 1'b0;
    tick();
    tick();
    check("no start after rst", busy16, 0);

    // Single word 0x3C, cycle-exact
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n <= 42; n++) begin
      if (n < 2) exp_tx = 1;
      else if (n < 6) exp_tx = 0;
      else if (n < 38) exp_tx = int'(b[(n - 6) / 4]);
      else exp_tx = 1;
      check($sformatf("w1 tx c%0d", n), tx1, exp_tx);
      check($sformatf("w1 done c%0d", n), done1, (n == 42) ? 1 : 0);
      check($sformatf("w1 busy c%0d", n), busy1, (n < 42) ? 1 : 0);
      if (n < 42) tick();
    end
    check("w1 addr", addr1, 0);

    // Full dump
    start_dump16();
    run_dump(700, -1);
    check_dump("full");

    // Start pulse in the middle of word 5
    start_dump16();
    run_dump(700, 230);
    start16 = 1'b0;
    check_dump("sbusy");
    extra = 0;
    repeat (60) begin
      tick();
      if (done16 === 1'b1) extra++;
    end
    check("sbusy extra done", extra, 0);
    check("sbusy idle", busy16, 0);

    // Reset during data bits of word 3
    start_dump16();
    repeat (140) tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    check("midrst tx", tx16, 1);
    check("midrst busy", busy16, 0);
    check("midrst done", done16, 0);
    check("midrst addr", addr16, 0);
    extra = 0;
    repeat (700) begin
      tick();
      if (done16 === 1'b1 || busy16 === 1'b1) extra++;
    end
    check("midrst quiet", extra, 0);
    start_dump16();
    run_dump(700, -1);
    check_dump("redump");

    // Back-to-back with start held high
    start16 = 1'b1;
    tick();
    check("b2b busy", busy16, 1);
    run_dump(700, -1);
    check_dump("b2b first");
    for (int i = 0; i < 16; i++) first[i] = frames[i];
    tick();
    check("b2b rebusy", busy16, 1);
    check("b2b readdr", addr16, 0);
    run_dump(700, -1);
    start16 = 1'b0;
    check("b2b2 frame count", n_frames, 16);
    check("b2b2 done cycle", done_cyc, 672);
    for (int i = 0; i < 16; i++)
      check($sformatf("b2b2 byte %0d", i), frames[i], first[i]);
    tick();
    check("b2b end idle", busy16, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
